uart_word_bridge: RTL and testbench
===================================

# uart_word_bridge

Parametrised word-to-byte bridge between the system side and the byte-level UART core, the successor to the fixed 32-bit system buffer. It serialises one WORD_BYTES-wide system word into UART byte transfers with a configurable byte order. It reassembles received bytes into words, discarding partial words after an inter-byte timeout. It also hosts a configurable-length majority filter on the raw serial RX line.

## Interface
Parameters:
- WORD_BYTES, 4, bytes per system word (≥1)
- MSB_FIRST, 1, 1: byte 0 on the wire is bits [8*WORD_BYTES-1 -: 8]; 0: byte 0 is bits [7:0]
- TIMEOUT_CYCLES, 10000, idle clocks after a byte before a partial RX word is dropped; 0 disables
- FILTER_TAPS, 3, majority window length on the RX serial line (odd, ≥3)

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- i_sys_data  in  8*WORD_BYTES  word to transmit
- sys_tx_data_valid  in  1  word strobe, accepted only when word_busy=0
- word_busy  out  1  TX word in progress
- o_sys_data  out  8*WORD_BYTES  last complete received word
- sys_rx_data_valid  out  1  one-cycle pulse, new o_sys_data
- rx_frame_err  out  1  one-cycle pulse, partial word discarded on timeout
- tx_data  out  8  byte to UART core
- tx_data_valid  out  1  one-cycle byte strobe to UART core
- tx_busy  in  1  UART core transmitting
- tx_done  in  1  one-cycle pulse, byte fully sent
- rx_data  in  8  byte from UART core
- rx_data_valid  in  1  one-cycle pulse, rx_data valid
- rx_serial_raw  in  1  raw serial RX line
- rx_serial_filt  out  1  majority-filtered serial line to UART core

## Operation
- The TX FSM is registered and has 3 states: IDLE, SEND and WAIT_DONE. word_busy = (state != IDLE).
- IDLE: on sys_tx_data_valid, latch i_sys_data, set byte_idx=0 and go to SEND. While word_busy=1, sys_tx_data_valid is ignored and never queued.
- SEND: when tx_busy=0, register tx_data = byte[byte_idx], pulse tx_data_valid for one cycle and go to WAIT_DONE. When tx_busy=1, hold in SEND.
- WAIT_DONE: on tx_done, if byte_idx = WORD_BYTES-1 go to IDLE; otherwise increment byte_idx and go to SEND. tx_done in any other state is ignored.
- RX assembler: on rx_data_valid, place rx_data at slot rx_cnt using the same byte order as TX, and increment rx_cnt.
  - On the byte that completes a word, register o_sys_data, pulse sys_rx_data_valid and set rx_cnt=0.
  - o_sys_data holds its value until the next complete word.
- Timeout: idle_cnt counts clocks while rx_cnt>0 and clears on every rx_data_valid.
  - When idle_cnt reaches TIMEOUT_CYCLES: set rx_cnt=0, pulse rx_frame_err and leave o_sys_data unchanged.
  - If rx_data_valid arrives on the expiry cycle, the byte wins: it is stored, the timer clears and there is no error.
- Filter: a FILTER_TAPS-bit shift register is reset to all ones (idle line). rx_serial_filt is the combinational majority of the register bits, so it changes only after (FILTER_TAPS+1)/2 consecutive agreeing samples.
- Widths:
  - byte_idx and rx_cnt are max(1, $clog2(WORD_BYTES)) bits.
  - idle_cnt is max(1, $clog2(TIMEOUT_CYCLES+1)) bits.
  - Counters never wrap; both are cleared at word boundaries.
- TX and RX paths are independent; full-duplex operation is required.

## Timing
- Reset values: word_busy 0, tx_data 0, tx_data_valid 0, o_sys_data 0, sys_rx_data_valid 0, rx_frame_err 0, rx_serial_filt 1, all counters 0, TX state IDLE.
- Reset mid-operation clears all state immediately. The partial TX word is abandoned, the partial RX word is lost, and no pulse is emitted.
- Word accepted at edge N: word_busy=1 from N. The first tx_data_valid is high from edge N+1 if tx_busy=0 at N+1.
- Between bytes: tx_done at edge M gives the next tx_data_valid at M+1, provided tx_busy=0.
- After the final tx_done at edge M, word_busy=0 from M, and a new word can be accepted at M+1.
- Final RX byte at edge K: o_sys_data updates and sys_rx_data_valid is high from edge K+1 for 1 cycle.
- Timeout expiry: rx_frame_err is high for exactly 1 cycle, TIMEOUT_CYCLES clocks after the last byte.
- Filter latency: (FILTER_TAPS+1)/2 clocks from a stable raw-line edge to the filtered-line edge.

## Structure
- Shared package uart_pkg holds:
  - BYTE_W=8
  - the TX state enum (IDLE, SEND, WAIT_DONE)
  - a majority function over a parameterised vector
- Sub-module rx_majority_filter, parameter TAPS, ports clk, rst_n, rx_in, rx_out. It supersedes the fixed 3-tap filter and is instantiated once inside uart_word_bridge.

## Test plan
- WORD_BYTES=4, MSB_FIRST=1, send 0xA1B2C3D4 with a tx_done model -> tx_data sequence A1,B2,C3,D4, four 1-cycle tx_data_valid pulses, word_busy low after the 4th tx_done.
- MSB_FIRST=0, feed rx bytes 11,22,33,44 -> o_sys_data=0x44332211 with a single sys_rx_data_valid pulse.
- TIMEOUT_CYCLES=20, feed 2 bytes then stay idle -> rx_frame_err pulse 20 clocks after the 2nd byte. Then feed a full 4 bytes -> a correct word.
- Strobe sys_tx_data_valid while word_busy=1 -> ignored, only the first word is sent. A byte arriving on the timeout-expiry cycle -> no error.
- FILTER_TAPS=5, 1-clock and 2-clock low glitches -> rx_serial_filt stays 1. A 3-clock low pulse -> rx_serial_filt goes 0 for 3 clocks.
- Assert rst_n low mid-word on both TX and RX -> all outputs at reset values. The next full word transfers cleanly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared constants, TX state type and majority vote helper
// for the UART word bridge and its RX line filter.
package uart_pkg;

  localparam int BYTE_W  = 8;
  localparam int MAJ_MAX = 64;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    WAIT_DONE
  } tx_state_e;

  // Votes over the low n bits of v; n must be odd and <= MAJ_MAX.
  function automatic logic majority(
    input logic [MAJ_MAX-1:0] v,
    input int                 n
  );
    int ones;
    ones = 0;
    for (int i = 0; i < MAJ_MAX; i++) begin
      if (i < n && v[i]) ones++;
    end
    return (2 * ones > n);
  endfunction

endpackage

// File: rtl/rx_majority_filter.sv
// Majority-vote deglitcher for the raw serial RX line.
// The window resets to all ones so the line reads idle.
module rx_majority_filter
  import uart_pkg::*;
#(
  parameter int TAPS = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic rx_in,
  output logic rx_out
);

  logic [TAPS-1:0]    r_sh;
  logic [MAJ_MAX-1:0] w_win;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sh <= '1;
    end else begin
      r_sh <= {r_sh[TAPS-2:0], rx_in};
    end
  end

  assign w_win  = MAJ_MAX'(r_sh);
  assign rx_out = majority(w_win, TAPS);

endmodule

// File: rtl/uart_word_bridge.sv
// Word <-> byte bridge to a byte-level UART core, with
// RX word reassembly, inter-byte timeout and RX line filter.
module uart_word_bridge
  import uart_pkg::*;
#(
  parameter int WORD_BYTES     = 4,
  parameter bit MSB_FIRST      = 1'b1,
  parameter int TIMEOUT_CYCLES = 10000,
  parameter int FILTER_TAPS    = 3
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [BYTE_W*WORD_BYTES-1:0] i_sys_data,
  input  logic                         sys_tx_data_valid,
  output logic                         word_busy,
  output logic [BYTE_W*WORD_BYTES-1:0] o_sys_data,
  output logic                         sys_rx_data_valid,
  output logic                         rx_frame_err,
  output logic [BYTE_W-1:0]            tx_data,
  output logic                         tx_data_valid,
  input  logic                         tx_busy,
  input  logic                         tx_done,
  input  logic [BYTE_W-1:0]            rx_data,
  input  logic                         rx_data_valid,
  input  logic                         rx_serial_raw,
  output logic                         rx_serial_filt
);

  localparam int WW = BYTE_W * WORD_BYTES;
  localparam int IW =
    ($clog2(WORD_BYTES) > 1) ? $clog2(WORD_BYTES) : 1;
  localparam int CW =
    ($clog2(TIMEOUT_CYCLES + 1) > 1) ?
    $clog2(TIMEOUT_CYCLES + 1) : 1;

  localparam logic [IW-1:0] LAST = IW'(WORD_BYTES - 1);
  localparam logic [CW-1:0] EXPIRE =
    CW'(TIMEOUT_CYCLES > 0 ? TIMEOUT_CYCLES - 1 : 0);

  // Bit offset of wire-order byte idx inside a word.
  function automatic int slot_lsb(input logic [IW-1:0] idx);
    if (MSB_FIRST)
      return BYTE_W * (WORD_BYTES - 1 - int'(idx));
    return BYTE_W * int'(idx);
  endfunction

  tx_state_e     r_state;
  tx_state_e     w_state_nxt;
  logic [WW-1:0] r_tx_word;
  logic [IW-1:0] r_byte_idx;
  logic          w_load;
  logic          w_fire;
  logic          w_adv;

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_fire      = 1'b0;
    w_adv       = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (sys_tx_data_valid) begin
          w_load      = 1'b1;
          w_state_nxt = SEND;
        end
      end
      SEND: begin
        if (!tx_busy) begin
          w_fire      = 1'b1;
          w_state_nxt = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (tx_done) begin
          if (r_byte_idx == LAST) begin
            w_state_nxt = IDLE;
          end else begin
            w_adv       = 1'b1;
            w_state_nxt = SEND;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_tx_word     <= '0;
      r_byte_idx    <= '0;
      tx_data       <= '0;
      tx_data_valid <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      tx_data_valid <= w_fire;
      if (w_load) begin
        r_tx_word  <= i_sys_data;
        r_byte_idx <= '0;
      end
      if (w_fire) begin
        tx_data <= r_tx_word[slot_lsb(r_byte_idx) +: BYTE_W];
      end
      if (w_adv) begin
        r_byte_idx <= r_byte_idx + IW'(1);
      end
    end
  end

  assign word_busy = (r_state != IDLE);

  logic [WW-1:0] r_rx_acc;
  logic [WW-1:0] w_rx_merged;
  logic [IW-1:0] r_rx_cnt;
  logic [CW-1:0] r_idle_cnt;
  logic          w_expire;
  logic          w_timing;

  always_comb begin
    w_rx_merged = r_rx_acc;
    w_rx_merged[slot_lsb(r_rx_cnt) +: BYTE_W] = rx_data;
  end

  // A byte on the expiry cycle takes priority over the error.
  assign w_timing = (TIMEOUT_CYCLES > 0) && (r_rx_cnt != '0);
  assign w_expire = w_timing && !rx_data_valid &&
                    (r_idle_cnt == EXPIRE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_acc          <= '0;
      r_rx_cnt          <= '0;
      r_idle_cnt        <= '0;
      o_sys_data        <= '0;
      sys_rx_data_valid <= 1'b0;
      rx_frame_err      <= 1'b0;
    end else begin
      sys_rx_data_valid <= 1'b0;
      rx_frame_err      <= 1'b0;
      if (rx_data_valid) begin
        r_rx_acc   <= w_rx_merged;
        r_idle_cnt <= '0;
        if (r_rx_cnt == LAST) begin
          o_sys_data        <= w_rx_merged;
          sys_rx_data_valid <= 1'b1;
          r_rx_cnt          <= '0;
        end else begin
          r_rx_cnt <= r_rx_cnt + IW'(1);
        end
      end else if (w_expire) begin
        r_rx_cnt     <= '0;
        r_idle_cnt   <= '0;
        rx_frame_err <= 1'b1;
      end else if (w_timing) begin
        r_idle_cnt <= r_idle_cnt + CW'(1);
      end
    end
  end

  rx_majority_filter #(
    .TAPS (FILTER_TAPS)
  ) u_filt (
    .clk    (clk),
    .rst_n  (rst_n),
    .rx_in  (rx_serial_raw),
    .rx_out (rx_serial_filt)
  );

endmodule

// File: tb/tb_uart_word_bridge.sv
// Randomised self-checking bench: MSB- and LSB-first bridges share
// stimulus and are compared every cycle against a transaction model.
module tb_uart_word_bridge;

  localparam int WB   = 4;
  localparam int TO   = 20;
  localparam int TAPS = 5;
  localparam int WW   = 8 * WB;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [WW-1:0] i_sys_data;
  logic          sys_tx_data_valid;
  logic          tx_busy;
  logic          tx_done;
  logic [7:0]    rx_data;
  logic          rx_data_valid;
  logic          rx_serial_raw;

  logic          busy0, busy1;
  logic [WW-1:0] osd0, osd1;
  logic          rxv0, rxv1;
  logic          err0, err1;
  logic [7:0]    txd0, txd1;
  logic          txv0, txv1;
  logic          filt0, filt1;

  always #5 clk = ~clk;

  uart_word_bridge #(
    .WORD_BYTES(WB), .MSB_FIRST(1'b1),
    .TIMEOUT_CYCLES(TO), .FILTER_TAPS(TAPS)
  ) u_msb (
    .clk(clk), .rst_n(rst_n),
    .i_sys_data(i_sys_data),
    .sys_tx_data_valid(sys_tx_data_valid),
    .word_busy(busy0), .o_sys_data(osd0),
    .sys_rx_data_valid(rxv0), .rx_frame_err(err0),
    .tx_data(txd0), .tx_data_valid(txv0),
    .tx_busy(tx_busy), .tx_done(tx_done),
    .rx_data(rx_data), .rx_data_valid(rx_data_valid),
    .rx_serial_raw(rx_serial_raw), .rx_serial_filt(filt0)
  );

  uart_word_bridge #(
    .WORD_BYTES(WB), .MSB_FIRST(1'b0),
    .TIMEOUT_CYCLES(TO), .FILTER_TAPS(TAPS)
  ) u_lsb (
    .clk(clk), .rst_n(rst_n),
    .i_sys_data(i_sys_data),
    .sys_tx_data_valid(sys_tx_data_valid),
    .word_busy(busy1), .o_sys_data(osd1),
    .sys_rx_data_valid(rxv1), .rx_frame_err(err1),
    .tx_data(txd1), .tx_data_valid(txv1),
    .tx_busy(tx_busy), .tx_done(tx_done),
    .rx_data(rx_data), .rx_data_valid(rx_data_valid),
    .rx_serial_raw(rx_serial_raw), .rx_serial_filt(filt1)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // ---------------- transaction model ----------------
  bit            m_busy, m_owe, m_infl, m_txv;
  int            m_sent;
  logic [WW-1:0] m_word;
  logic [7:0]    m_txd [2];
  logic [7:0]    m_rxq [$];
  int            m_now, m_last;
  logic [WW-1:0] m_out [2];
  bit            m_rxv, m_err, m_filt;
  bit            m_hist [$];

  function automatic logic [7:0] byte_at(input logic [WW-1:0] w,
                                         input int k, input bit msb);
    int sh;
    sh = msb ? 8 * (WB - 1 - k) : 8 * k;
    return 8'(w >> sh);
  endfunction

  function automatic logic [WW-1:0] assemble(input bit msb);
    logic [WW-1:0] w;
    w = '0;
    for (int k = 0; k < WB; k++) begin
      if (msb) w = (w << 8) | WW'(m_rxq[k]);
      else     w = w | (WW'(m_rxq[k]) << (8 * k));
    end
    return w;
  endfunction

  task automatic model_reset();
    m_busy = 0; m_owe = 0; m_infl = 0; m_txv = 0; m_sent = 0;
    m_word = '0; m_txd[0] = '0; m_txd[1] = '0;
    m_rxq.delete(); m_last = 0;
    m_out[0] = '0; m_out[1] = '0;
    m_rxv = 0; m_err = 0; m_filt = 1;
    m_hist.delete();
    for (int i = 0; i < TAPS; i++) m_hist.push_back(1'b1);
  endtask

  task automatic model_step();
    int ones;
    m_now++;
    m_txv = 0;
    if (!m_busy) begin
      if (sys_tx_data_valid) begin
        m_busy = 1; m_word = i_sys_data; m_sent = 0; m_owe = 1;
      end
    end else if (m_owe) begin
      if (!tx_busy) begin
        m_txv = 1;
        m_txd[0] = byte_at(m_word, m_sent, 1'b1);
        m_txd[1] = byte_at(m_word, m_sent, 1'b0);
        m_owe = 0; m_infl = 1;
      end
    end else if (m_infl && tx_done) begin
      m_infl = 0;
      m_sent++;
      if (m_sent == WB) m_busy = 0;
      else m_owe = 1;
    end
    m_rxv = 0; m_err = 0;
    if (rx_data_valid) begin
      m_rxq.push_back(rx_data);
      m_last = m_now;
      if (m_rxq.size() == WB) begin
        m_out[0] = assemble(1'b1);
        m_out[1] = assemble(1'b0);
        m_rxq.delete();
        m_rxv = 1;
      end
    end else if (m_rxq.size() > 0 && m_now - m_last == TO) begin
      m_err = 1;
      m_rxq.delete();
    end
    m_hist.push_back(rx_serial_raw);
    void'(m_hist.pop_front());
    ones = 0;
    foreach (m_hist[i]) if (m_hist[i]) ones++;
    m_filt = (2 * ones > TAPS);
  endtask

  initial begin
    m_now = 0;
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_step();
    end
  end

  // ---------------- compare process ----------------
  int         cyc_c = 0;
  int         rx_pulses = 0;
  int         err_pulses = 0;
  int         err_cyc = 0;
  int         filt_lows = 0;
  logic [7:0] obs_tx0 [$];
  logic [7:0] obs_tx1 [$];

  initial begin
    forever begin
      @(posedge clk);
      #1;
      cyc_c++;
      chk("word_busy msb", 64'(busy0), 64'(m_busy));
      chk("word_busy lsb", 64'(busy1), 64'(m_busy));
      chk("tx_data_valid msb", 64'(txv0), 64'(m_txv));
      chk("tx_data_valid lsb", 64'(txv1), 64'(m_txv));
      chk("tx_data msb", 64'(txd0), 64'(m_txd[0]));
      chk("tx_data lsb", 64'(txd1), 64'(m_txd[1]));
      chk("o_sys_data msb", 64'(osd0), 64'(m_out[0]));
      chk("o_sys_data lsb", 64'(osd1), 64'(m_out[1]));
      chk("sys_rx_data_valid msb", 64'(rxv0), 64'(m_rxv));
      chk("sys_rx_data_valid lsb", 64'(rxv1), 64'(m_rxv));
      chk("rx_frame_err msb", 64'(err0), 64'(m_err));
      chk("rx_frame_err lsb", 64'(err1), 64'(m_err));
      chk("rx_serial_filt msb", 64'(filt0), 64'(m_filt));
      chk("rx_serial_filt lsb", 64'(filt1), 64'(m_filt));
      if (txv0) obs_tx0.push_back(txd0);
      if (txv1) obs_tx1.push_back(txd1);
      if (rxv0) rx_pulses++;
      if (err0) begin
        err_pulses++;
        err_cyc = cyc_c;
      end
      if (!filt0) filt_lows++;
    end
  end

  // ---------------- UART core model ----------------
  initial begin
    int left;
    bit serving;
    tx_busy = 0; tx_done = 0; serving = 0; left = 0;
    forever begin
      @(negedge clk);
      tx_done = 0;
      if (!rst_n) begin
        serving = 0; tx_busy = 0;
      end else if (serving) begin
        if (left == 0) begin
          tx_done = 1; tx_busy = 0; serving = 0;
        end else begin
          left--;
        end
      end else if (txv0) begin
        serving = 1; tx_busy = 1;
        left = $urandom_range(0, 3);
      end else begin
        tx_busy = ($urandom_range(0, 3) == 0);
        tx_done = ($urandom_range(0, 7) == 0);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic rx_byte(input logic [7:0] b);
    rx_data = b; rx_data_valid = 1;
    @(negedge clk);
    rx_data_valid = 0;
  endtask

  task automatic tx_word(input logic [WW-1:0] w);
    i_sys_data = w; sys_tx_data_valid = 1;
    @(negedge clk);
    sys_tx_data_valid = 0;
  endtask

  task automatic wait_tx_idle(input string nm);
    int n;
    n = 0;
    while (busy0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk(nm, 64'(n < 500), 64'd1);
  endtask

  task automatic glitch(input int len);
    filt_lows = 0;
    rx_serial_raw = 0;
    tick(len);
    rx_serial_raw = 1;
    tick(10);
  endtask

  logic [7:0] e_hi [4];
  logic [7:0] e_cf [4];

  initial begin
    int t0, n, quiet;
    e_hi = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    e_cf = '{8'hCA, 8'hFE, 8'hF0, 8'h0D};
    rst_n = 0; i_sys_data = '0; sys_tx_data_valid = 0;
    rx_data = '0; rx_data_valid = 0; rx_serial_raw = 1;
    tick(3);
    chk("rst word_busy", 64'(busy0), 64'd0);
    chk("rst tx_data", 64'(txd0), 64'd0);
    chk("rst tx_data_valid", 64'(txv0), 64'd0);
    chk("rst o_sys_data", 64'(osd0), 64'd0);
    chk("rst sys_rx_data_valid", 64'(rxv0), 64'd0);
    chk("rst rx_frame_err", 64'(err0), 64'd0);
    chk("rst rx_serial_filt", 64'(filt0), 64'd1);
    rst_n = 1;
    tick(2);

    obs_tx0.delete(); obs_tx1.delete();
    tx_word(32'hA1B2C3D4);
    tick(2);
    chk("busy during word", 64'(busy0), 64'd1);
    tx_word(32'h0BADF00D);
    wait_tx_idle("tx word 1 completes");
    tick(3);
    chk("tx byte count", 64'(obs_tx0.size()), 64'd4);
    for (int k = 0; k < 4; k++) begin
      chk("tx msb-first byte", 64'(obs_tx0[k]), 64'(e_hi[k]));
      chk("tx lsb-first byte", 64'(obs_tx1[k]), 64'(e_hi[3-k]));
    end

    rx_pulses = 0;
    rx_byte(8'h11); rx_byte(8'h22); tick(3);
    rx_byte(8'h33); rx_byte(8'h44); tick(2);
    chk("rx lsb-first word", 64'(osd1), 64'h44332211);
    chk("rx msb-first word", 64'(osd0), 64'h11223344);
    chk("rx pulse count", 64'(rx_pulses), 64'd1);

    err_pulses = 0;
    rx_byte(8'h55); rx_byte(8'h66);
    t0 = cyc_c;
    n = 0;
    while (err_pulses == 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    tick(3);
    chk("timeout latency", 64'(err_cyc - t0), 64'd20);
    chk("timeout pulse count", 64'(err_pulses), 64'd1);
    chk("word held after timeout", 64'(osd0), 64'h11223344);
    rx_byte(8'hC0); rx_byte(8'hFF); rx_byte(8'hEE); rx_byte(8'h01);
    tick(2);
    chk("word after timeout msb", 64'(osd0), 64'hC0FFEE01);
    chk("word after timeout lsb", 64'(osd1), 64'h01EEFFC0);

    err_pulses = 0;
    rx_byte(8'h10); tick(19);
    rx_byte(8'h20); tick(19);
    rx_byte(8'h30); tick(19);
    rx_byte(8'h40); tick(25);
    chk("byte on expiry no error", 64'(err_pulses), 64'd0);
    chk("byte on expiry word", 64'(osd0), 64'h10203040);

    glitch(1);
    chk("1-clock glitch", 64'(filt_lows), 64'd0);
    glitch(2);
    chk("2-clock glitch", 64'(filt_lows), 64'd0);
    glitch(3);
    chk("3-clock pulse low cycles", 64'(filt_lows), 64'd3);

    quiet = 0;
    for (int c = 0; c < 3000; c++) begin
      sys_tx_data_valid = ($urandom_range(0, 9) == 0);
      i_sys_data = $urandom;
      rx_data = 8'($urandom);
      if (quiet > 0) begin
        quiet--;
        rx_data_valid = 0;
      end else if ($urandom_range(0, 39) == 0) begin
        quiet = $urandom_range(15, 30);
        rx_data_valid = 0;
      end else begin
        rx_data_valid = ($urandom_range(0, 3) == 0);
      end
      if ($urandom_range(0, 3) == 0) rx_serial_raw = ~rx_serial_raw;
      @(negedge clk);
    end
    sys_tx_data_valid = 0; rx_data_valid = 0; rx_serial_raw = 1;
    tick(10);
    wait_tx_idle("tx idle after random");

    tx_word(32'h12345678);
    rx_byte(8'hAA); rx_byte(8'hBB);
    tick(2);
    rst_n = 0;
    #1;
    chk("mid rst word_busy", 64'(busy0), 64'd0);
    chk("mid rst tx_data", 64'(txd0), 64'd0);
    chk("mid rst tx_data_valid", 64'(txv0), 64'd0);
    chk("mid rst o_sys_data", 64'(osd0), 64'd0);
    chk("mid rst rx_frame_err", 64'(err0), 64'd0);
    tick(3);
    rst_n = 1;
    tick(2);
    obs_tx0.delete(); obs_tx1.delete();
    rx_pulses = 0; err_pulses = 0;
    tx_word(32'hCAFEF00D);
    rx_byte(8'h5A); rx_byte(8'hA5); rx_byte(8'h3C); rx_byte(8'hC3);
    wait_tx_idle("tx word after reset completes");
    tick(3);
    chk("post-reset tx count", 64'(obs_tx0.size()), 64'd4);
    for (int k = 0; k < 4; k++) begin
      chk("post-reset tx byte", 64'(obs_tx0[k]), 64'(e_cf[k]));
    end
    chk("post-reset rx word", 64'(osd0), 64'h5AA53CC3);
    chk("post-reset rx pulses", 64'(rx_pulses), 64'd1);
    chk("post-reset no error", 64'(err_pulses), 64'd0);

    tick(5);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
